// File: rtl/instr_sequencer.sv
// Purpose: fetch/decode/execute controller running LOAD/MOV/ADD/HALT out of a 32-word ROM
//          against an internal 8x16 register file.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC); a HALT word stops after FETCH+DECODE.
// Backpressure: none; the ROM is combinational and start is only sampled in IDLE/HALT.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 level, begins execution at PC=0 from IDLE or HALT
//   rom_addr / rom_code   PC out, 23-bit instruction word in
//   busy, halted          FETCH/DECODE/EXEC, HALT indicators
//   reg_we/waddr/wdata    one-cycle write-back strobe with held address/data
//   carry                 carry-out of the most recent ADD
//   dbg_sel / dbg_data    combinational register file read port
module instr_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [22:0]       rom_code,
  output logic              busy,
  output logic              halted,
  output logic              reg_we,
  output logic [2:0]        reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              carry,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [22:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic              we_q, we_d;
  logic [2:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              carry_q, carry_d;
  logic              add_q, add_d;       // instruction in EXEC is an ADD
  logic              add_c_q, add_c_d;   // its carry-out, committed at end of EXEC

  logic [3:0]        ir_op;
  logic [2:0]        ir_dst;
  logic [2:0]        ir_src;
  logic [15:0]       ir_imm;
  logic [DATA_W:0]   sum;

  assign ir_op  = ir_q[22:19];
  assign ir_dst = ir_q[18:16];
  assign ir_src = ir_q[15:13];
  assign ir_imm = ir_q[15:0];

  // Operands are read in DECODE, before any write of this instruction, so
  // MOV Rn,Rn and ADD Rn,Rn see the old value.
  assign sum = {1'b0, rf_q[ir_dst]} + {1'b0, rf_q[ir_src]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    carry_d = carry_q;
    add_d   = add_q;
    add_c_d = add_c_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = rom_code;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        add_d = 1'b0;
        if (ir_op == OP_HALT) begin
          // PC is left pointing at the HALT word.
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
          // Address/data only move for real writes so they hold across NOPs.
          case (ir_op)
            OP_LOAD: begin
              we_d    = 1'b1;
              waddr_d = ir_dst;
              wdata_d = ir_imm;
            end
            OP_MOV: begin
              we_d    = 1'b1;
              waddr_d = ir_dst;
              wdata_d = rf_q[ir_src];
            end
            OP_ADD: begin
              we_d    = 1'b1;
              waddr_d = ir_dst;
              wdata_d = sum[DATA_W-1:0];
              add_d   = 1'b1;
              add_c_d = sum[DATA_W];
            end
            default: we_d = 1'b0;
          endcase
        end
      end
      S_EXEC: begin
        we_d    = 1'b0;
        add_d   = 1'b0;
        if (add_q) carry_d = add_c_q;
        pc_d    = pc_q + 1'b1;   // wraps 31 -> 0
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      carry_q <= 1'b0;
      add_q   <= 1'b0;
      add_c_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      carry_q <= carry_d;
      add_q   <= add_d;
      add_c_q <= add_c_d;
      // Commit at the end of EXEC so the next DECODE sees the result.
      if (state_q == S_EXEC && we_q) rf_q[waddr_q] <= wdata_q;
    end
  end

  assign rom_addr  = pc_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted    = (state_q == S_HALT);
  assign reg_we    = we_q;
  assign reg_waddr = waddr_q;
  assign reg_wdata = wdata_q;
  assign carry     = carry_q;
  assign dbg_data  = rf_q[dbg_sel];

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  rom_addr;
  logic [22:0] rom_code;
  logic        busy, halted, reg_we, carry;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic [2:0]  dbg_sel = 3'd0;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  logic [22:0] rom [32];
  assign rom_code = rom[rom_addr];

  instr_sequencer #(.ADDR_W(5), .DATA_W(16), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_code(rom_code),
    .busy(busy), .halted(halted),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .carry(carry), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  we_pulses = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [22:0] f_load(input logic [2:0] d, input logic [15:0] imm);
    return {4'b0001, d, imm};
  endfunction
  function automatic logic [22:0] f_mov(input logic [2:0] d, input logic [2:0] s);
    return {4'b0010, d, s, 13'd0};
  endfunction
  function automatic logic [22:0] f_add(input logic [2:0] d, input logic [2:0] s);
    return {4'b0011, d, s, 13'd0};
  endfunction

  function automatic wr_t mk(input logic [2:0] a, input logic [15:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  // Write-back monitor: pops the scoreboard on every strobe.
  int  last_we_cyc = 0;
  bit  have_last = 0;
  bit  prev_we = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_last = 0;
      prev_we   = 0;
    end else begin
      if (!busy) have_last = 0;
      if (reg_we) begin
        wr_t e;
        we_pulses++;
        chk("we_one_cycle", {31'd0, prev_we}, 32'd0);
        if (have_last) chk("we_spacing", cyc - last_we_cyc, 3);
        have_last   = 1;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL we_unexpected: got waddr=%0d wdata=0x%0h expected no write", reg_waddr, reg_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("we_waddr", {29'd0, reg_waddr}, {29'd0, e.a});
          chk("we_wdata", {16'd0, reg_wdata}, {16'd0, e.d});
        end
      end
      prev_we = reg_we;
    end
  end

  task automatic chk_reg(input int r, input logic [15:0] v);
    dbg_sel = r[2:0];
    #1;
    chk($sformatf("R%0d", r), {16'd0, dbg_data}, {16'd0, v});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},   {31'd0, busy},   0);
    chk({tag, "_halted"}, {31'd0, halted}, 0);
    chk({tag, "_we"},     {31'd0, reg_we}, 0);
    chk({tag, "_waddr"},  {29'd0, reg_waddr}, 0);
    chk({tag, "_wdata"},  {16'd0, reg_wdata}, 0);
    chk({tag, "_carry"},  {31'd0, carry},  0);
    chk({tag, "_addr"},   {27'd0, rom_addr}, 0);
    for (int r = 0; r < 8; r++) chk_reg(r, 16'h0000);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);   // start-sampling edge
    #1;
    start = 1'b0;
  endtask

  // Counts cycles after the start-sampling edge; cycle 1 spans that edge to the next.
  task automatic wait_halt(input logic [15:0] r3_exp, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("restart_pc", {27'd0, rom_addr}, 0);
        chk("restart_busy", {31'd0, busy}, 1);
        chk_reg(3, r3_exp);
      end
      if (halted) break;
      if (n >= 500) begin
        checks++;
        errors++;
        $display("FAIL halt_timeout: no halt after %0d cycles", n);
        break;
      end
    end
  endtask

  task automatic load_main();
    logic [15:0] vals [8];
    vals = '{16'd12, 16'd9, 16'd3, 16'd20, 16'd13, 16'd21, 16'd25, 16'd30};
    for (int i = 0; i < 32; i++) rom[i] = 23'd0;
    for (int i = 0; i < 8; i++) begin
      rom[i] = f_load(i[2:0], vals[i]);
      exp_q.push_back(mk(i[2:0], vals[i]));
    end
    rom[8]  = f_mov(3'd0, 3'd4);  exp_q.push_back(mk(3'd0, 16'd13));
    rom[9]  = f_mov(3'd5, 3'd7);  exp_q.push_back(mk(3'd5, 16'd30));
    rom[10] = f_mov(3'd2, 3'd1);  exp_q.push_back(mk(3'd2, 16'd9));
    rom[11] = f_add(3'd3, 3'd0);  exp_q.push_back(mk(3'd3, 16'd33));
    rom[12] = 23'd0;
  endtask

  task automatic check_main_final();
    logic [15:0] fin [8];
    fin = '{16'd13, 16'd9, 16'd9, 16'd33, 16'd13, 16'd30, 16'd25, 16'd30};
    for (int r = 0; r < 8; r++) chk_reg(r, fin[r]);
    chk("main_carry", {31'd0, carry}, 0);
    chk("main_halt_addr", {27'd0, rom_addr}, 32'h0C);
    chk("hold_waddr", {29'd0, reg_waddr}, 3);
    chk("hold_wdata", {16'd0, reg_wdata}, 33);
    chk("main_queue", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int base;
    logic [4:0] prev_addr;
    bit busy_ok;
    bit wrap_seen;
    bit step_ok;

    for (int i = 0; i < 32; i++) rom[i] = 23'd0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_addr", {27'd0, rom_addr}, 0);

    // ADD overflow: 0xFFFF + 2 = 0x0001 carry 1.
    rom[0] = f_load(3'd1, 16'hFFFF); exp_q.push_back(mk(3'd1, 16'hFFFF));
    rom[1] = f_load(3'd2, 16'h0002); exp_q.push_back(mk(3'd2, 16'h0002));
    rom[2] = f_add(3'd1, 3'd2);      exp_q.push_back(mk(3'd1, 16'h0001));
    rom[3] = 23'd0;
    do_start();
    wait_halt(16'h0000, n);
    chk("ovf_cycles", n, 3 * 3 + 3);
    chk_reg(1, 16'h0001);
    chk("ovf_carry", {31'd0, carry}, 1);
    chk("ovf_halt_addr", {27'd0, rom_addr}, 3);

    // Restart from HALT with ADD R2,R2: doubling, carry clears, R1 kept.
    rom[0] = f_add(3'd2, 3'd2);      exp_q.push_back(mk(3'd2, 16'h0004));
    rom[1] = 23'd0;
    do_start();
    wait_halt(16'h0000, n);
    chk_reg(2, 16'h0004);
    chk_reg(1, 16'h0001);
    chk("dbl_carry", {31'd0, carry}, 0);

    // Main program.
    load_main();
    base = we_pulses;
    do_start();
    wait_halt(16'h0000, n);
    chk("main_halt_cycle", n, 39);
    chk("main_pulses", we_pulses - base, 12);
    check_main_final();

    // Re-run from HALT: registers carried over, same results.
    load_main();
    base = we_pulses;
    do_start();
    wait_halt(16'd33, n);
    chk("rerun_halt_cycle", n, 39);
    chk("rerun_pulses", we_pulses - base, 12);
    check_main_final();

    // NOP everywhere: PC wraps, no writes, never halts.
    for (int i = 0; i < 32; i++) rom[i] = {4'b0111, 19'd0};
    base = we_pulses;
    do_start();
    busy_ok   = 1;
    wrap_seen = 0;
    step_ok   = 1;
    prev_addr = rom_addr;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (!busy) busy_ok = 0;
      if (rom_addr != prev_addr) begin
        if (rom_addr != 5'(prev_addr + 5'd1)) step_ok = 0;
        if (prev_addr == 5'd31 && rom_addr == 5'd0) wrap_seen = 1;
      end
      prev_addr = rom_addr;
    end
    chk("nop_busy", {31'd0, busy_ok}, 1);
    chk("nop_wrap", {31'd0, wrap_seen}, 1);
    chk("nop_step", {31'd0, step_ok}, 1);
    chk("nop_pulses", we_pulses - base, 0);

    // Reset during EXEC of an ADD: nothing may land afterwards.
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 23'd0;
    rom[0] = f_load(3'd1, 16'd5); exp_q.push_back(mk(3'd1, 16'd5));
    rom[1] = f_add(3'd1, 3'd1);   exp_q.push_back(mk(3'd1, 16'd10));
    @(negedge clk);
    rst_n = 1'b1;
    base = we_pulses;
    do_start();
    n = 0;
    while (we_pulses < base + 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_reached_add_exec", we_pulses - base, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset("idle_after");
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetch/decode/execute controller that sits directly downstream of the 32-entry instruction ROM.
- Drives the ROM address from an internal program counter and registers the returned 23-bit instruction word.
- Decodes LOAD/MOV/ADD/HALT and executes them against an internal 8x16 register file.
- Exposes write-back strobes and a debug read port so the datapath and display logic can observe results.

Parameters:
- ADDR_W, 5, program counter / ROM address width
- DATA_W, 16, register and immediate width
- NREGS, 8, register file depth (3-bit register fields)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; sampled in IDLE or HALT to begin execution at PC=0
- rom_addr  output  ADDR_W  current PC, fed to the ROM address input
- rom_code  input  23  instruction word from the combinational ROM
- busy  output  1  high in FETCH/DECODE/EXEC
- halted  output  1  high in HALT
- reg_we  output  1  one-cycle write-back strobe
- reg_waddr  output  3  destination register of the current write
- reg_wdata  output  DATA_W  value written
- carry  output  1  carry-out of the most recent ADD
- dbg_sel  input  3  debug register select
- dbg_data  output  DATA_W  combinational read of R[dbg_sel]

Behaviour:
- Instruction format:
  - [22:19] opcode
  - [18:16] dst
  - [15:0] imm16 for LOAD
  - [15:13] src for MOV/ADD; [12:0] ignored
- Opcodes:
  - 0000 HALT
  - 0001 LOAD: R[dst] <= imm16
  - 0010 MOV: R[dst] <= R[src]
  - 0011 ADD: R[dst] <= R[dst] + R[src], modulo 2^16; carry <= bit 16 of the sum
  - 0100-1111: NOP (PC advances, no write)
- Reset (async, rst_n low):
  - state = IDLE, PC = 0, IR = 0, all registers = 0
  - carry = 0, reg_we = 0, reg_waddr = 0, reg_wdata = 0
  - busy = 0, halted = 0
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: start=1 -> FETCH with PC=0.
  - FETCH: IR <= rom_code, where rom_addr = PC throughout FETCH -> DECODE.
  - DECODE:
    - opcode 0000 -> HALT; PC holds and points at the HALT word.
    - otherwise operands latched from R[dst]/R[src] -> EXEC.
  - EXEC:
    - Result computed.
    - reg_we = 1 for exactly this cycle for LOAD/MOV/ADD; register file written at the end of EXEC.
    - PC <= PC + 1 -> FETCH.
  - HALT: start=1 -> PC=0 -> FETCH. Register contents are retained; there is no register clear except reset.
- Timing:
  - Exactly 3 cycles per non-HALT instruction.
  - A write in EXEC is visible to the next instruction's DECODE; no hazards.
- Wrap-around: PC at 31 after EXEC wraps to 0 and execution continues. No implicit halt.
- MOV with src = dst and ADD R,R (doubling) are legal; operands are read before the write.
- carry changes only on ADD and holds its value otherwise.
- start is ignored while busy.
- reg_wdata/reg_waddr hold their last values when reg_we = 0.
- Reset asserted mid-instruction aborts immediately; no partial write occurs after rst_n rises.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-EXEC of an ADD.
  - Required: all outputs 0 and dbg_data=0 for every dbg_sel; start=0 keeps IDLE, rom_addr=0.
- Program:
  - Stimulus: ROM holds LOAD R0..R7 = 12,9,3,20,13,21,25,30; MOV R0,R4; MOV R5,R7; MOV R2,R1; ADD R3,R0; then HALT at 0x0C.
  - Required: final R0=13, R2=9, R3=33, R5=30, carry=0.
  - Required: halted rises 39 cycles after the start-sampling edge, with rom_addr=0x0C.
- Write strobe:
  - Stimulus: the same program.
  - Required: exactly 12 reg_we pulses, each one cycle wide and spaced 3 cycles apart; 4th pulse carries waddr=3, wdata=0x0014.
- ADD overflow:
  - Stimulus: LOAD R1 0xFFFF; LOAD R2 0x0002; ADD R1,R2.
  - Required: R1=0x0001, carry=1.
  - Stimulus: a following ADD R2,R2.
  - Required: R2=0x0004, carry=0.
- NOP/wrap:
  - Stimulus: ROM with opcode 0111 at all 32 addresses.
  - Required: no reg_we; rom_addr steps 31 -> 0; busy stays high.
- Restart:
  - Stimulus: start=1 in HALT.
  - Required: PC=0, registers preserved; re-running the program reproduces identical final values.
